// File: rtl/reg_file_rename_pkg.sv
// Shared widths, types and the read-port resolution function for the renaming
// architectural register file.
package reg_file_rename_pkg;

   localparam int REG_NUM    = 32;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int TAG_W      = 4;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [XLEN-1:0]       data_t;
   typedef logic [TAG_W-1:0]      tag_t;

   localparam reg_addr_t ZERO_REG = '0;

   typedef enum logic {
      REG_VALID = 1'b0,
      REG_BUSY  = 1'b1
   } reg_state_e;

   // What dispatch sees for one source operand.
   typedef struct packed {
      logic  busy;
      tag_t  tag;
      data_t data;
   } read_t;

   // A pending register whose producer is committing this cycle is forwarded
   // as ready, so dispatch never captures a tag that is about to retire.
   function automatic read_t resolve_read(
      input reg_addr_t addr,
      input logic      busy,
      input tag_t      tag,
      input data_t     data,
      input logic      commit_valid,
      input reg_addr_t commit_reg,
      input tag_t      commit_tag,
      input data_t     commit_data
   );
      read_t r;
      r = '{busy: 1'b0, tag: '0, data: '0};
      if (addr != ZERO_REG) begin
         if (busy && commit_valid && (commit_reg == addr) && (commit_tag == tag)) begin
            r.data = commit_data;
         end else if (busy) begin
            r.busy = 1'b1;
            r.tag  = tag;
         end else begin
            r.data = data;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/reg_file_rename_if.sv
// Dispatch read ports, rename request and ROB commit bus of the register file.
interface reg_file_rename_if;
   import reg_file_rename_pkg::*;

   reg_addr_t rs1_addr;
   logic      rs1_busy;
   tag_t      rs1_tag;
   data_t     rs1_data;

   reg_addr_t rs2_addr;
   logic      rs2_busy;
   tag_t      rs2_tag;
   data_t     rs2_data;

   logic      rename_valid;
   reg_addr_t rename_reg;
   tag_t      rename_tag;

   logic      commit_valid;
   reg_addr_t commit_reg;
   tag_t      commit_tag;
   data_t     commit_data;

   modport master (
      output rs1_addr, rs2_addr,
      output rename_valid, rename_reg, rename_tag,
      output commit_valid, commit_reg, commit_tag, commit_data,
      input  rs1_busy, rs1_tag, rs1_data,
      input  rs2_busy, rs2_tag, rs2_data
   );

   modport slave (
      input  rs1_addr, rs2_addr,
      input  rename_valid, rename_reg, rename_tag,
      input  commit_valid, commit_reg, commit_tag, commit_data,
      output rs1_busy, rs1_tag, rs1_data,
      output rs2_busy, rs2_tag, rs2_data
   );

endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register busy bit and producing ROB tag;
// renamed at issue, retired by ROB commit, flushed by clear.
module reg_file_rename
   import reg_file_rename_pkg::*;
(
   input logic               clk,
   input logic               rst,
   input logic               rdy,
   input logic               clear,
   reg_file_rename_if.slave  rf
);

   logic [REG_NUM-1:0] busy_q, busy_d;
   tag_t               tag_q  [REG_NUM];
   tag_t               tag_d  [REG_NUM];
   data_t              data_q [REG_NUM];
   data_t              data_d [REG_NUM];

   logic  rename_fire;
   logic  commit_fire;
   logic  commit_retires;
   read_t rd1, rd2;

   assign rename_fire = rf.rename_valid && (rf.rename_reg != ZERO_REG) && !clear;
   assign commit_fire = rf.commit_valid && (rf.commit_reg != ZERO_REG);
   // A commit only retires the mapping if it is still the youngest producer.
   assign commit_retires = commit_fire
                        && (tag_q[rf.commit_reg] == rf.commit_tag)
                        && !(rename_fire && (rf.rename_reg == rf.commit_reg));

   // NOTE: every next-state value gets its hold default before any branch, so
   // no path through this block leaves a signal unassigned and infers a latch.
   always_comb begin
      busy_d = busy_q;
      tag_d  = tag_q;
      data_d = data_q;

      if (clear) begin
         busy_d = '0;
      end

      if (commit_fire) begin
         data_d[rf.commit_reg] = rf.commit_data;
         if (commit_retires) begin
            busy_d[rf.commit_reg] = REG_VALID;
         end
      end

      if (rename_fire) begin
         busy_d[rf.rename_reg] = REG_BUSY;
         tag_d[rf.rename_reg]  = rf.rename_tag;
      end
   end

   // NOTE: the register array is reset because reads are architecturally
   // required to return zero right after reset, not just the status bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: state uses non-blocking assignment so every element updates
         // from the same pre-edge values regardless of statement order.
         busy_q <= '0;
         tag_q  <= '{default: '0};
         data_q <= '{default: '0};
      end else if (rdy) begin
         busy_q <= busy_d;
         tag_q  <= tag_d;
         data_q <= data_d;
      end
   end

   assign rd1 = resolve_read(rf.rs1_addr, busy_q[rf.rs1_addr], tag_q[rf.rs1_addr],
                             data_q[rf.rs1_addr], rf.commit_valid, rf.commit_reg,
                             rf.commit_tag, rf.commit_data);
   assign rd2 = resolve_read(rf.rs2_addr, busy_q[rf.rs2_addr], tag_q[rf.rs2_addr],
                             data_q[rf.rs2_addr], rf.commit_valid, rf.commit_reg,
                             rf.commit_tag, rf.commit_data);

   assign rf.rs1_busy = rd1.busy;
   assign rf.rs1_tag  = rd1.tag;
   assign rf.rs1_data = rd1.data;
   assign rf.rs2_busy = rd2.busy;
   assign rf.rs2_tag  = rd2.tag;
   assign rf.rs2_data = rd2.data;

endmodule

// File: tb/tb_reg_file_rename.sv
// Directed self-checking bench for reg_file_rename: rename, commit, bypass,
// stale commits, flush, x0 and stall behaviour.
module tb_reg_file_rename;
   import reg_file_rename_pkg::*;

   logic clk;
   logic rst;
   logic rdy;
   logic clear;
   int   errors;
   int   checks;

   reg_file_rename_if rf ();

   reg_file_rename dut (
      .clk   (clk),
      .rst   (rst),
      .rdy   (rdy),
      .clear (clear),
      .rf    (rf.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      clear           = 1'b0;
      rf.rename_valid = 1'b0;
      rf.rename_reg   = '0;
      rf.rename_tag   = '0;
      rf.commit_valid = 1'b0;
      rf.commit_reg   = '0;
      rf.commit_tag   = '0;
      rf.commit_data  = '0;
   endtask

   task automatic do_rename(input reg_addr_t r, input tag_t t);
      rf.rename_valid = 1'b1;
      rf.rename_reg   = r;
      rf.rename_tag   = t;
   endtask

   task automatic do_commit(input reg_addr_t r, input tag_t t, input data_t d);
      rf.commit_valid = 1'b1;
      rf.commit_reg   = r;
      rf.commit_tag   = t;
      rf.commit_data  = d;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rdy = 1'b1;
      idle();
      rf.rs1_addr = 5'd5;
      rf.rs2_addr = 5'd0;
      step();
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'h0 || rf.rs1_tag !== 4'h0) begin
         errors++;
         $display("FAIL reset_rs1: got busy=%0b tag=%0h data=%h want 0/0/0",
                  rf.rs1_busy, rf.rs1_tag, rf.rs1_data);
      end
      checks++;
      if (rf.rs2_busy !== 1'b0 || rf.rs2_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_rs2: got busy=%0b data=%h want 0/0", rf.rs2_busy, rf.rs2_data);
      end
   endtask

   task automatic test_rename_commit();
      do_rename(5'd3, 4'd7);
      step();
      idle();
      rf.rs1_addr = 5'd3;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b1 || rf.rs1_tag !== 4'd7) begin
         errors++;
         $display("FAIL x3_renamed: got busy=%0b tag=%0d want 1/7", rf.rs1_busy, rf.rs1_tag);
      end
      do_commit(5'd3, 4'd7, 32'h1234);
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'h1234) begin
         errors++;
         $display("FAIL x3_bypass: got busy=%0b data=%h want 0/00001234", rf.rs1_busy, rf.rs1_data);
      end
      step();
      idle();
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'h1234) begin
         errors++;
         $display("FAIL x3_committed: got busy=%0b data=%h want 0/00001234", rf.rs1_busy, rf.rs1_data);
      end
   endtask

   task automatic test_stale_commit();
      do_rename(5'd4, 4'd2);
      step();
      do_rename(5'd4, 4'd5);
      step();
      idle();
      do_commit(5'd4, 4'd2, 32'hAA);
      rf.rs1_addr = 5'd4;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b1 || rf.rs1_tag !== 4'd5) begin
         errors++;
         $display("FAIL x4_old_tag_no_bypass: got busy=%0b tag=%0d want 1/5", rf.rs1_busy, rf.rs1_tag);
      end
      step();
      idle();
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b1 || rf.rs1_tag !== 4'd5 || rf.rs1_data !== 32'h0) begin
         errors++;
         $display("FAIL x4_still_busy: got busy=%0b tag=%0d data=%h want 1/5/0",
                  rf.rs1_busy, rf.rs1_tag, rf.rs1_data);
      end
      do_commit(5'd4, 4'd5, 32'hBB);
      step();
      idle();
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'hBB) begin
         errors++;
         $display("FAIL x4_retired: got busy=%0b data=%h want 0/000000bb", rf.rs1_busy, rf.rs1_data);
      end
   endtask

   task automatic test_rename_commit_same();
      do_rename(5'd6, 4'd1);
      step();
      idle();
      do_rename(5'd6, 4'd9);
      do_commit(5'd6, 4'd1, 32'h55);
      rf.rs2_addr = 5'd6;
      #1;
      checks++;
      if (rf.rs2_busy !== 1'b0 || rf.rs2_data !== 32'h55) begin
         errors++;
         $display("FAIL x6_same_cycle_read: got busy=%0b data=%h want 0/00000055", rf.rs2_busy, rf.rs2_data);
      end
      step();
      idle();
      #1;
      checks++;
      if (rf.rs2_busy !== 1'b1 || rf.rs2_tag !== 4'd9) begin
         errors++;
         $display("FAIL x6_rename_wins: got busy=%0b tag=%0d want 1/9", rf.rs2_busy, rf.rs2_tag);
      end
   endtask

   task automatic test_clear();
      do_rename(5'd1, 4'd1);
      step();
      do_rename(5'd2, 4'd2);
      step();
      do_rename(5'd3, 4'd3);
      step();
      idle();
      clear = 1'b1;
      do_rename(5'd8, 4'd3);
      do_commit(5'd2, 4'd2, 32'h77);
      step();
      idle();
      rf.rs1_addr = 5'd1;
      rf.rs2_addr = 5'd3;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'h0 || rf.rs2_busy !== 1'b0 || rf.rs2_data !== 32'h1234) begin
         errors++;
         $display("FAIL clear_x1_x3: got busy=%0b/%0b data=%h/%h want 0/0 00000000/00001234",
                  rf.rs1_busy, rf.rs2_busy, rf.rs1_data, rf.rs2_data);
      end
      rf.rs1_addr = 5'd8;
      rf.rs2_addr = 5'd2;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs2_busy !== 1'b0 || rf.rs2_data !== 32'h77) begin
         errors++;
         $display("FAIL clear_x8_x2: got busy=%0b/%0b x2=%h want 0/0 00000077",
                  rf.rs1_busy, rf.rs2_busy, rf.rs2_data);
      end
      rf.rs1_addr = 5'd6;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'h55) begin
         errors++;
         $display("FAIL clear_x6_data: got busy=%0b data=%h want 0/00000055", rf.rs1_busy, rf.rs1_data);
      end
   endtask

   task automatic test_x0_and_stall();
      do_rename(5'd0, 4'd4);
      do_commit(5'd0, 4'd4, 32'hFF);
      rf.rs1_addr = 5'd0;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'h0) begin
         errors++;
         $display("FAIL x0_no_bypass: got busy=%0b data=%h want 0/0", rf.rs1_busy, rf.rs1_data);
      end
      step();
      idle();
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_tag !== 4'h0 || rf.rs1_data !== 32'h0) begin
         errors++;
         $display("FAIL x0_after_write: got busy=%0b tag=%0d data=%h want 0/0/0",
                  rf.rs1_busy, rf.rs1_tag, rf.rs1_data);
      end
      rdy = 1'b0;
      do_rename(5'd9, 4'd6);
      do_commit(5'd3, 4'd0, 32'hDEAD);
      step();
      step();
      idle();
      rdy = 1'b1;
      rf.rs1_addr = 5'd9;
      rf.rs2_addr = 5'd3;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs2_data !== 32'h1234) begin
         errors++;
         $display("FAIL stall_hold: got x9_busy=%0b x3=%h want 0/00001234", rf.rs1_busy, rf.rs2_data);
      end
   endtask

   task automatic test_back_to_back();
      do_rename(5'd10, 4'd10);
      step();
      idle();
      do_commit(5'd10, 4'd10, 32'hC0DE);
      do_rename(5'd11, 4'd11);
      step();
      idle();
      rf.rs1_addr = 5'd10;
      rf.rs2_addr = 5'd11;
      #1;
      checks++;
      if (rf.rs1_busy !== 1'b0 || rf.rs1_data !== 32'hC0DE) begin
         errors++;
         $display("FAIL b2b_x10: got busy=%0b data=%h want 0/0000c0de", rf.rs1_busy, rf.rs1_data);
      end
      checks++;
      if (rf.rs2_busy !== 1'b1 || rf.rs2_tag !== 4'd11) begin
         errors++;
         $display("FAIL b2b_x11: got busy=%0b tag=%0d want 1/11", rf.rs2_busy, rf.rs2_tag);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_rename_commit();
      test_stale_commit();
      test_rename_commit_same();
      test_clear();
      test_x0_and_stall();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
